svm_det_collector: RTL and testbench

Downstream consumer of the synchronised SVM classifier output stream (is_person / result / sw_id / o_valid).
- Tracks frame boundaries from the slide-window index.
- Buffers positive detections (sw_id plus score) in a FIFO for a valid/ready readout master such as the host bridge or box drawer.
- Produces a per-frame summary: detection count, best-scoring window, overflow and error flags.
- The SVM side has no backpressure, so the block accepts every input beat unconditionally.

---
 rtl/svm_pkg.sv | 10 +
 rtl/svm_det_fifo.sv | 44 ++++
 rtl/svm_det_collector.sv | 113 +++++++++++
 tb/tb_svm_det_collector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// svm_pkg: shared widths and FSM encoding for the SVM detection collector.
package svm_pkg;
    localparam int FEA_I  = 4;
    localparam int FEA_F  = 28;
    localparam int FEA_W  = FEA_I + FEA_F;
    localparam int SW_W   = 11;
    localparam int NUM_SW = 2048;
    localparam int DET_W  = SW_W + FEA_W;
    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
endpackage

// File: rtl/svm_det_fifo.sv
// svm_det_fifo: synchronous first-word fall-through FIFO; a push while full is taken only alongside a pop.
module svm_det_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == (AW+1)'(DEPTH);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/svm_det_collector.sv
// svm_det_collector: frames the SVM classifier stream, queues positive windows and
// publishes a per-frame summary (count, best window, overflow, truncation).
module svm_det_collector
    import svm_pkg::*;
#(
    parameter int NUM_SW = svm_pkg::NUM_SW,
    parameter int DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_is_person,
    input  logic [FEA_W-1:0] i_result,
    input  logic [SW_W-1:0]  i_sw_id,
    output logic             det_valid,
    input  logic             det_ready,
    output logic [SW_W-1:0]  det_sw_id,
    output logic [FEA_W-1:0] det_score,
    output logic             frame_done,
    output logic             frame_err,
    output logic [SW_W:0]    frame_det_cnt,
    output logic             best_valid,
    output logic [SW_W-1:0]  best_sw_id,
    output logic [FEA_W-1:0] best_score,
    output logic             overflow
);
    localparam logic [SW_W:0]   CNT_MAX = {1'b1, {SW_W{1'b0}}};
    localparam logic [SW_W-1:0] LAST_ID = SW_W'(NUM_SW - 1);

    state_t state_q, state_d;
    logic [SW_W:0] cnt_q, cnt_d, base_cnt, fcnt_q, fcnt_d;
    logic bv_q, bv_d, base_bv, fbv_q, fbv_d;
    logic [SW_W-1:0] bid_q, bid_d, fbid_q, fbid_d;
    logic [FEA_W-1:0] bs_q, bs_d, fbs_q, fbs_d;
    logic ovf_q, ovf_d, done_q, done_d, err_q, err_d;
    logic start, last, accept, abort, pos, new_best, fifo_full, fifo_empty;

    always_comb begin
        start    = i_sw_id == '0;
        last     = i_sw_id == LAST_ID;
        accept   = i_valid && (state_q == COLLECT || start);
        abort    = i_valid && state_q == COLLECT && start;
        pos      = accept && i_is_person;
        // A frame-opening beat sees a cleared running state before it is folded in.
        base_cnt = start ? '0 : cnt_q;
        base_bv  = start ? 1'b0 : bv_q;
        new_best = pos && (!base_bv || $signed(i_result) > $signed(bs_q));
        cnt_d    = !accept ? cnt_q :
                   (pos && base_cnt != CNT_MAX) ? base_cnt + (SW_W+1)'(1) : base_cnt;
        bv_d     = accept ? (base_bv || pos) : bv_q;
        bid_d    = new_best ? i_sw_id : bid_q;
        bs_d     = new_best ? i_result : bs_q;
        ovf_d    = accept ? ((ovf_q && !start) || (pos && fifo_full && !det_ready)) : ovf_q;
        done_d   = accept && (last || abort);
        err_d    = abort;
        // An abort summarises the frame as it stood before the restarting beat.
        fcnt_d   = !done_d ? fcnt_q : abort ? cnt_q : cnt_d;
        fbv_d    = !done_d ? fbv_q  : abort ? bv_q  : bv_d;
        fbid_d   = !done_d ? fbid_q : abort ? bid_q : bid_d;
        fbs_d    = !done_d ? fbs_q  : abort ? bs_q  : bs_d;
        state_d  = !accept ? state_q : last ? IDLE : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bv_q    <= 1'b0;
            bid_q   <= '0;
            bs_q    <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            fbv_q   <= 1'b0;
            fbid_q  <= '0;
            fbs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bv_q    <= bv_d;
            bid_q   <= bid_d;
            bs_q    <= bs_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            fbv_q   <= fbv_d;
            fbid_q  <= fbid_d;
            fbs_q   <= fbs_d;
        end
    end

    svm_det_fifo #(.DEPTH(DEPTH), .WIDTH(DET_W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (pos),
        .wr_data({i_sw_id, i_result}),
        .full   (fifo_full),
        .pop    (det_ready),
        .rd_data({det_sw_id, det_score}),
        .empty  (fifo_empty)
    );

    assign det_valid     = !fifo_empty;
    assign frame_done    = done_q;
    assign frame_err     = err_q;
    assign frame_det_cnt = fcnt_q;
    assign best_valid    = fbv_q;
    assign best_sw_id    = fbid_q;
    assign best_score    = fbs_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_svm_det_collector.sv
// tb_svm_det_collector: randomized and directed stimulus scored against a queue-based frame model.
module tb_svm_det_collector;
    import svm_pkg::*;
    localparam int NSW = 8;
    localparam int DEP = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic i_valid = 1'b0, i_is_person = 1'b0, det_ready = 1'b0;
    logic [FEA_W-1:0] i_result = '0;
    logic [SW_W-1:0] i_sw_id = '0;
    logic det_valid, frame_done, frame_err, best_valid, overflow;
    logic [SW_W-1:0] det_sw_id, best_sw_id;
    logic [FEA_W-1:0] det_score, best_score;
    logic [SW_W:0] frame_det_cnt;

    svm_det_collector #(.NUM_SW(NSW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_is_person(i_is_person),
        .i_result(i_result), .i_sw_id(i_sw_id), .det_valid(det_valid),
        .det_ready(det_ready), .det_sw_id(det_sw_id), .det_score(det_score),
        .frame_done(frame_done), .frame_err(frame_err), .frame_det_cnt(frame_det_cnt),
        .best_valid(best_valid), .best_sw_id(best_sw_id), .best_score(best_score),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [SW_W-1:0] id; logic [FEA_W-1:0] sc;} ent_t;
    typedef struct packed {logic err; int cnt; logic bv; logic [SW_W-1:0] id; logic [FEA_W-1:0] sc;} sum_t;

    ent_t exp_q[$];
    ent_t pos_q[$];
    sum_t sum_q[$];
    int occ = 0, pops = 0, checks = 0, failures = 0;
    bit in_frame = 0, m_ovf = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Frame summary derived from the list of positives: count, and first strict maximum.
    task automatic end_frame(input bit err);
        sum_t s;
        s.err = err;
        s.cnt = pos_q.size();
        s.bv  = pos_q.size() != 0;
        s.id  = '0;
        s.sc  = '0;
        foreach (pos_q[i])
            if (i == 0 || $signed(pos_q[i].sc) > $signed(s.sc)) begin
                s.id = pos_q[i].id;
                s.sc = pos_q[i].sc;
            end
        sum_q.push_back(s);
    endtask

    task automatic model_step();
        bit pop, acc, pushed;
        ent_t e;
        pop = det_ready && occ > 0;
        pushed = 0;
        acc = i_valid && (in_frame || i_sw_id == 0);
        if (acc) begin
            if (in_frame && i_sw_id == 0) end_frame(1);
            if (i_sw_id == 0) begin
                pos_q.delete();
                m_ovf = 0;
                in_frame = 1;
            end
            if (i_is_person) begin
                e.id = i_sw_id;
                e.sc = i_result;
                pos_q.push_back(e);
                if (occ < DEP || pop) begin
                    exp_q.push_back(e);
                    pushed = 1;
                end else m_ovf = 1;
            end
            if (i_sw_id == NSW - 1) begin
                end_frame(0);
                in_frame = 0;
            end
        end
        occ = occ + int'(pushed) - int'(pop);
    endtask

    task automatic cyc(input bit v, input bit p, input logic [FEA_W-1:0] sc, input int id, input bit rdy);
        i_valid = v;
        i_is_person = p;
        i_result = sc;
        i_sw_id = SW_W'(id);
        det_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        chk("overflow", overflow, m_ovf);
        chk("det_valid", det_valid, occ != 0);
    endtask

    task automatic do_reset(input int n);
        i_valid = 0;
        det_ready = 0;
        rst = 0;
        occ = 0;
        exp_q.delete();
        sum_q.delete();
        pos_q.delete();
        in_frame = 0;
        m_ovf = 0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_det_valid", det_valid, 0);
        chk("rst_det_sw_id", det_sw_id, 0);
        chk("rst_det_score", det_score, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_cnt", frame_det_cnt, 0);
        chk("rst_best_valid", best_valid, 0);
        chk("rst_best_sw_id", best_sw_id, 0);
        chk("rst_best_score", best_score, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1;
    endtask

    // Monitor: pops expected detections on each handshake and expected summaries on frame_done.
    bit hold = 0;
    logic [DET_W-1:0] hold_d;
    always @(negedge clk) begin
        if (!rst) hold = 0;
        else begin
            if (hold) begin
                chk("head_hold_valid", det_valid, 1);
                chk("head_hold_data", {det_sw_id, det_score}, hold_d);
            end
            if (det_valid && det_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop got=%0h exp=none", {det_sw_id, det_score});
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("pop_sw_id", det_sw_id, e.id);
                    chk("pop_score", det_score, e.sc);
                    pops++;
                end
            end
            hold = det_valid && !det_ready;
            hold_d = {det_sw_id, det_score};
            if (frame_done) begin
                if (sum_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done got=1 exp=0");
                end else begin
                    sum_t s;
                    s = sum_q.pop_front();
                    chk("sum_err", frame_err, s.err);
                    chk("sum_cnt", frame_det_cnt, s.cnt);
                    chk("sum_best_valid", best_valid, s.bv);
                    if (s.bv) begin
                        chk("sum_best_sw_id", best_sw_id, s.id);
                        chk("sum_best_score", best_score, s.sc);
                    end
                end
            end else chk("err_without_done", frame_err, 0);
        end
    end

    initial begin
        int p0;
        do_reset(3);
        for (int id = 3; id < NSW; id++) cyc(1, 1, 32'h0500_0000, id, 0);
        chk("idle_ignored_valid", det_valid, 0);

        for (int id = 0; id < NSW; id++)
            cyc(1, id == 2 || id == 5 || id == 6, id == 2 ? 32'h0100_0000 : 32'h0300_0000, id, 1);
        chk("t1_done", frame_done, 1);
        chk("t1_err", frame_err, 0);
        chk("t1_cnt", frame_det_cnt, 3);
        chk("t1_best_id", best_sw_id, 5);
        chk("t1_best_sc", best_score, 32'h0300_0000);
        repeat (3) cyc(0, 0, 0, 0, 1);

        for (int id = 0; id < NSW; id++)
            cyc(1, id == 1 || id == 3, id == 1 ? 32'hF000_0000 : 32'hE000_0000, id, 1);
        chk("t2_best_id", best_sw_id, 1);
        chk("t2_cnt", frame_det_cnt, 2);
        for (int id = 0; id < NSW; id++) cyc(1, 0, 32'h0700_0000, id, 1);
        chk("t2_none_bv", best_valid, 0);
        chk("t2_none_cnt", frame_det_cnt, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        for (int id = 0; id < NSW; id++) cyc(1, id < 6, $urandom, id, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_cnt", frame_det_cnt, 6);
        p0 = pops;
        repeat (8) cyc(0, 0, 0, 0, 1);
        chk("t3_drained", pops - p0, 4);

        for (int id = 0; id < NSW; id++) cyc(1, id < 5, $urandom, id, id == 4);
        chk("t4_overflow", overflow, 0);
        chk("t4_full_valid", det_valid, 1);
        p0 = pops;
        repeat (8) cyc(0, 0, 0, 0, 1);
        chk("t4_drained", pops - p0, 4);

        for (int id = 0; id < 5; id++) cyc(1, id == 1 || id == 3, $urandom, id, 1);
        cyc(1, 1, 32'h0200_0000, 0, 1);
        chk("t5_done", frame_done, 1);
        chk("t5_err", frame_err, 1);
        chk("t5_cnt", frame_det_cnt, 2);
        for (int id = 1; id < NSW; id++) cyc(1, 0, $urandom, id, 1);
        chk("t5_new_done", frame_done, 1);
        chk("t5_new_err", frame_err, 0);
        chk("t5_new_cnt", frame_det_cnt, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        for (int f = 0; f < 40; f++) begin
            int stop;
            stop = ($urandom % 5 == 0) ? int'($urandom_range(1, 6)) : NSW;
            if ($urandom % 3 == 0) cyc(1, 1, $urandom, int'($urandom_range(1, NSW - 1)), $urandom % 2 == 0);
            for (int id = 0; id < stop; id++) begin
                while ($urandom % 4 == 0) cyc(0, 0, 0, 0, $urandom % 2 == 0);
                cyc(1, $urandom % 3 == 0, $urandom, id, $urandom % 4 != 0);
            end
        end
        repeat (10) cyc(0, 0, 0, 0, 1);

        for (int id = 0; id < 4; id++) cyc(1, 1, $urandom, id, 0);
        cyc(0, 0, 0, 0, 0);
        do_reset(2);
        for (int id = 4; id < NSW; id++) cyc(1, 1, $urandom, id, 1);
        chk("t6_no_done", frame_done, 0);
        chk("t6_empty", det_valid, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("sum_queue_empty", sum_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
